// File: rtl/spart_fifo_if.sv
// Processor-side bus of the SPART: access strobes plus the two ready flags.
// The bidirectional databus stays a plain port on the SPART itself.
interface spart_fifo_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, iorw, ioaddr, input rda, tbr);
   modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_fifo.sv
// Byte-wide SPART: processor register port to an 8N1 serial line.
// It has a programmable baud divisor, TX/RX FIFOs and sticky overrun/framing flags.
module spart_fifo #(
   parameter int               FIFO_DEPTH  = 4,
   parameter int               DIV_W       = 16,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(5208)
) (
   input  logic         clk,
   input  logic         rst_n,
   spart_fifo_if.slave  bus,
   inout  wire  [7:0]   databus,
   output logic         txd,
   input  logic         rxd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

   logic [7:0]       tx_mem [FIFO_DEPTH];
   logic [7:0]       rx_mem [FIFO_DEPTH];
   logic [PW-1:0]    tx_wp, tx_rp, rx_wp, rx_rp, tx_count, rx_count;
   logic             tx_empty, tx_full, rx_empty, rx_full;
   logic             tx_push, tx_pop, rx_push, rx_pop, rx_done, ovr_set, ferr_set;
   logic             cs_rd, cs_wr, status_rd, ovr, ferr, tx_busy;
   logic [DIV_W-1:0] div_reg, eff_div;
   logic [15:0]      div_pad;
   logic [7:0]       status, rd_data;

   tx_state_t        tx_state, tx_state_n;
   logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
   logic [2:0]       tx_bit, tx_bit_n;
   logic [7:0]       tx_shift, tx_shift_n;

   rx_state_t        rx_state, rx_state_n;
   logic [DIV_W-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
   logic [2:0]       rx_bit, rx_bit_n;
   logic [7:0]       rx_shift, rx_shift_n;
   logic             rx_s1, rx_s2, rx_prev;

   assign cs_rd     = bus.iocs && bus.iorw;
   assign cs_wr     = bus.iocs && !bus.iorw;
   assign status_rd = cs_rd && (bus.ioaddr == 2'd1);

   assign tx_count = tx_wp - tx_rp;
   assign rx_count = rx_wp - rx_rp;
   assign tx_empty = (tx_count == '0);
   assign rx_empty = (rx_count == '0);
   assign tx_full  = (tx_count == PW'(FIFO_DEPTH));
   assign rx_full  = (rx_count == PW'(FIFO_DEPTH));

   // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
   assign tx_push = cs_wr && (bus.ioaddr == 2'd0) && (!tx_full || tx_pop);
   assign rx_pop  = cs_rd && (bus.ioaddr == 2'd0) && !rx_empty;
   assign rx_push = rx_done && (!rx_full || rx_pop);
   assign ovr_set = rx_done && rx_full && !rx_pop;

   assign bus.rda = !rx_empty;
   assign bus.tbr = !tx_full;
   assign tx_busy = (tx_state != TX_IDLE);
   assign eff_div = (div_reg < DIV_W'(2)) ? DIV_W'(2) : div_reg;
   assign div_pad = 16'(div_reg);
   assign status  = {ovr, ferr, tx_busy, tx_empty, 4'(rx_count)};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wp[AW-1:0]] <= databus;
            tx_wp <= tx_wp + PW'(1);
         end
         if (tx_pop) tx_rp <= tx_rp + PW'(1);
         if (rx_push) begin
            rx_mem[rx_wp[AW-1:0]] <= rx_shift;
            rx_wp <= rx_wp + PW'(1);
         end
         if (rx_pop) rx_rp <= rx_rp + PW'(1);
      end
   end

   // Error flags are sticky: a new error on the clearing edge wins over the status read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_reg <= DEFAULT_DIV;
         ovr     <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         if (cs_wr && bus.ioaddr == 2'd2) div_reg[7:0] <= databus;
         if (cs_wr && bus.ioaddr == 2'd3) div_reg[DIV_W-1:8] <= databus[DIV_W-9:0];
         ovr  <= ovr_set  || (ovr  && !status_rd);
         ferr <= ferr_set || (ferr && !status_rd);
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (bus.ioaddr)
         2'd0:    rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
         2'd1:    rd_data = status;
         2'd2:    rd_data = div_pad[7:0];
         default: rd_data = div_pad[15:8];
      endcase
   end

   assign databus = cs_rd ? rd_data : 8'bz;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= DEFAULT_DIV;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_div   <= tx_div_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
      end
   end

   // The divisor is captured at each frame start so register writes never stretch a live frame.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt + DIV_W'(1);
      tx_div_n   = tx_div;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_pop     = 1'b0;
      txd        = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            tx_cnt_n = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_state_n = TX_START;
               tx_div_n   = eff_div;
               tx_shift_n = tx_mem[tx_rp[AW-1:0]];
            end
         end
         TX_START: begin
            txd = 1'b0;
            if (tx_cnt == tx_div - DIV_W'(1)) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               tx_state_n = TX_DATA;
            end
         end
         TX_DATA: begin
            txd = tx_shift[0];
            if (tx_cnt == tx_div - DIV_W'(1)) begin
               tx_cnt_n   = '0;
               tx_shift_n = {1'b0, tx_shift[7:1]};
               tx_bit_n   = tx_bit + 3'd1;
               if (tx_bit == 3'd7) tx_state_n = TX_STOP;
            end
         end
         default: begin
            if (tx_cnt == tx_div - DIV_W'(1)) begin
               tx_cnt_n   = '0;
               tx_state_n = TX_IDLE;
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_state_n = TX_START;
                  tx_div_n   = eff_div;
                  tx_shift_n = tx_mem[tx_rp[AW-1:0]];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DEFAULT_DIV;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_s1    <= rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_div   <= rx_div_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
      end
   end

   // Start bit is re-checked at its midpoint; after that every sample lands mid-bit.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + DIV_W'(1);
      rx_div_n   = rx_div;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_done    = 1'b0;
      ferr_set   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (!rx_s2 && rx_prev) begin
               rx_state_n = RX_START;
               rx_div_n   = eff_div;
            end
         end
         RX_START: begin
            if (rx_cnt == (rx_div >> 1) - DIV_W'(1)) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == rx_div - DIV_W'(1)) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_s2, rx_shift[7:1]};
               rx_bit_n   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == rx_div - DIV_W'(1)) begin
               rx_cnt_n = '0;
               if (rx_s2) begin
                  rx_done    = 1'b1;
                  rx_state_n = RX_IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  rx_state_n = RX_WAIT;
               end
            end
         end
         default: begin
            rx_cnt_n = '0;
            if (rx_s2) rx_state_n = RX_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_spart_fifo.sv
// Directed bench for spart_fifo: register map, TX framing, loopback RX, FIFO limits and error flags.
module tb_spart_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd_drv = 1'b1;
   logic       loopback = 1'b0;
   logic       drive_bus = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd;
   wire  [7:0] databus;
   wire        txd;
   wire        rxd;
   int         n_checks = 0;
   int         n_pass = 0;
   int         n_fail = 0;

   spart_fifo_if bus_if ();

   spart_fifo dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus_if),
      .databus (databus),
      .txd     (txd),
      .rxd     (rxd)
   );

   assign databus = drive_bus ? wr_data : 8'bz;
   assign rxd     = loopback ? txd : rxd_drv;

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      n_checks++;
      assert (observed === expected) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One bus access: set up on a falling edge, taken on the next rising edge.
   task automatic apply_stimulus(input logic rw, input logic [1:0] addr, input logic [7:0] wdata,
                                 output logic [7:0] rdata);
      @(negedge clk);
      bus_if.iocs   = 1'b1;
      bus_if.iorw   = rw;
      bus_if.ioaddr = addr;
      wr_data       = wdata;
      drive_bus     = !rw;
      #1 rdata = databus;
      @(negedge clk);
      bus_if.iocs = 1'b0;
      drive_bus   = 1'b0;
   endtask

   task automatic set_div(input logic [15:0] d);
      logic [7:0] dummy;
      apply_stimulus(1'b0, 2'd2, d[7:0], dummy);
      apply_stimulus(1'b0, 2'd3, d[15:8], dummy);
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return d[idx-1];
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
      for (int i = 0; i < 10; i++) begin
         rxd_drv = (i == 9) ? stop : frame_bit(d, i);
         repeat (div) @(negedge clk);
      end
   endtask

   task automatic wait_rda(input int budget);
      int n = 0;
      while (bus_if.rda !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output("rda_wait", {7'b0, bus_if.rda}, 8'h01);
   endtask

   initial begin
      bus_if.iocs   = 1'b0;
      bus_if.iorw   = 1'b0;
      bus_if.ioaddr = 2'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state and register defaults
      check_output("rst_txd", {7'b0, txd}, 8'h01);
      check_output("rst_rda", {7'b0, bus_if.rda}, 8'h00);
      check_output("rst_tbr", {7'b0, bus_if.tbr}, 8'h01);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("rst_status", rd, 8'h10);
      apply_stimulus(1'b1, 2'd2, 8'h00, rd);
      check_output("rst_div_lo", rd, 8'h58);
      apply_stimulus(1'b1, 2'd3, 8'h00, rd);
      check_output("rst_div_hi", rd, 8'h14);

      // Single 0x55 frame at divisor 8, sampled every clock
      set_div(16'd8);
      apply_stimulus(1'b0, 2'd0, 8'h55, rd);
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         check_output("t2_txd", {7'b0, txd}, {7'b0, frame_bit(8'h55, k / 8)});
         if (k == 40) begin
            bus_if.iocs   = 1'b1;
            bus_if.iorw   = 1'b1;
            bus_if.ioaddr = 2'd1;
            #1 check_output("t2_status_busy", databus, 8'h30);
         end else begin
            bus_if.iocs = 1'b0;
         end
      end
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t2_status_idle", rd, 8'h10);
      check_output("t2_txd_idle", {7'b0, txd}, 8'h01);

      // Loopback at divisor 4
      set_div(16'd4);
      loopback = 1'b1;
      apply_stimulus(1'b0, 2'd0, 8'hA3, rd);
      apply_stimulus(1'b0, 2'd0, 8'h3C, rd);
      wait_rda(200);
      apply_stimulus(1'b1, 2'd0, 8'h00, rd);
      check_output("t3_byte0", rd, 8'hA3);
      check_output("t3_rda_after0", {7'b0, bus_if.rda}, 8'h00);
      wait_rda(200);
      apply_stimulus(1'b1, 2'd0, 8'h00, rd);
      check_output("t3_byte1", rd, 8'h3C);
      check_output("t3_rda_after1", {7'b0, bus_if.rda}, 8'h00);
      apply_stimulus(1'b1, 2'd0, 8'h00, rd);
      check_output("t3_empty_read", rd, 8'h00);

      // Six back-to-back writes at divisor 16: five go out, the sixth is dropped
      set_div(16'd16);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus_if.iocs   = 1'b1;
         bus_if.iorw   = 1'b0;
         bus_if.ioaddr = 2'd0;
         wr_data       = 8'(8'h11 * (i + 1));
         drive_bus     = 1'b1;
      end
      @(negedge clk);
      bus_if.iocs = 1'b0;
      drive_bus   = 1'b0;
      check_output("t4_tbr_full", {7'b0, bus_if.tbr}, 8'h00);
      for (int i = 0; i < 5; i++) begin
         wait_rda(400);
         apply_stimulus(1'b1, 2'd0, 8'h00, rd);
         check_output("t4_order", rd, 8'(8'h11 * (i + 1)));
      end
      repeat (300) @(negedge clk);
      check_output("t4_no_sixth", {7'b0, bus_if.rda}, 8'h00);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t4_status", rd, 8'h10);

      // RX overrun with five frames and no reads
      loopback = 1'b0;
      rxd_drv  = 1'b1;
      set_div(16'd8);
      repeat (4) @(negedge clk);
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 8);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t5_status_ovr", rd, 8'h94);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t5_status_clr", rd, 8'h14);
      for (int i = 1; i <= 4; i++) begin
         apply_stimulus(1'b1, 2'd0, 8'h00, rd);
         check_output("t5_data", rd, 8'(i));
      end
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t5_status_empty", rd, 8'h10);

      // Overrun landing on the same edge as a status read
      for (int i = 1; i <= 4; i++) send_frame(8'(8'hA0 + i), 1'b1, 8);
      fork
         send_frame(8'hA5, 1'b1, 8);
         begin
            repeat (78) @(negedge clk);
            bus_if.iocs   = 1'b1;
            bus_if.iorw   = 1'b1;
            bus_if.ioaddr = 2'd1;
            #1 rd = databus;
            @(negedge clk);
            bus_if.iocs = 1'b0;
         end
      join
      check_output("t5_same_edge_pre", rd, 8'h14);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t5_same_edge_ovr", rd, 8'h94);
      for (int i = 1; i <= 4; i++) begin
         apply_stimulus(1'b1, 2'd0, 8'h00, rd);
         check_output("t5_drain", rd, 8'(8'hA0 + i));
      end
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t5_status_final", rd, 8'h10);

      // Framing error
      send_frame(8'h5A, 1'b0, 8);
      rxd_drv = 1'b1;
      repeat (10) @(negedge clk);
      check_output("t6_ferr_rda", {7'b0, bus_if.rda}, 8'h00);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t6_ferr_status", rd, 8'h50);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t6_ferr_clear", rd, 8'h10);

      // Short low pulse is rejected, then a real frame still arrives
      rxd_drv = 1'b0;
      repeat (3) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (40) @(negedge clk);
      check_output("t6_glitch_rda", {7'b0, bus_if.rda}, 8'h00);
      apply_stimulus(1'b1, 2'd1, 8'h00, rd);
      check_output("t6_glitch_status", rd, 8'h10);
      send_frame(8'h3E, 1'b1, 8);
      wait_rda(50);
      apply_stimulus(1'b1, 2'd0, 8'h00, rd);
      check_output("t6_after_glitch", rd, 8'h3E);

      // Divisor change while a frame is on the wire
      @(negedge clk);
      bus_if.iocs   = 1'b1;
      bus_if.iorw   = 1'b0;
      bus_if.ioaddr = 2'd0;
      wr_data       = 8'h0F;
      drive_bus     = 1'b1;
      @(negedge clk);
      wr_data = 8'hF0;
      @(negedge clk);
      bus_if.ioaddr = 2'd2;
      wr_data       = 8'h04;
      @(negedge clk);
      bus_if.iocs = 1'b0;
      drive_bus   = 1'b0;
      for (int k = 1; k < 124; k++) begin
         logic exp_txd;
         if (k < 80)       exp_txd = frame_bit(8'h0F, k / 8);
         else if (k < 120) exp_txd = frame_bit(8'hF0, (k - 80) / 4);
         else              exp_txd = 1'b1;
         check_output("t6_div_change_txd", {7'b0, txd}, {7'b0, exp_txd});
         @(negedge clk);
      end
      apply_stimulus(1'b1, 2'd2, 8'h00, rd);
      check_output("t6_div_readback", rd, 8'h04);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
